// File: rtl/vmu_spm_arb_pkg.sv
// -----------------------------------------------------------------------------
// vmu_spm_arb_pkg
// Shared types and constants for the VMU/DMA scratchpad arbiter.
//   arb_state_e : per-channel ownership state (IDLE / OWN_VMU / OWN_DMA)
//   REQ_VMU/DMA : requester encodings used for the rr pointer and read tags
//   rd_tag_t    : {vld, src} entry of the read-return tag pipeline
// -----------------------------------------------------------------------------
package vmu_spm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_VMU = 2'd1,
    OWN_DMA = 2'd2
  } arb_state_e;

  localparam logic REQ_VMU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef struct packed {
    logic vld;
    logic src;
  } rd_tag_t;

  // The requester that is not 'req'.
  function automatic logic other_req(input logic req);
    return ~req;
  endfunction

endpackage

// File: rtl/spm_arb_ch.sv
// -----------------------------------------------------------------------------
// spm_arb_ch
// One arbitration channel (used once for reads, once for writes): ownership
// FSM, round-robin pointer and combinational grant generation.
//
// Configuration macro: SPM_ARB_VMU_PRIO_EN
//   defined   -> VMU wins every tie in IDLE, no rr pointer exists
//   undefined -> ties in IDLE go to the rr pointer side
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_vmu_en / i_dma_en     beat request from each requester
//   i_vmu_last / i_dma_last last beat of the requester's burst
//   o_vmu_gnt / o_dma_gnt   grant (beat accepted when en && gnt)
//   o_acc                   a beat is accepted this cycle
//   o_sel                   requester of the accepted beat (REQ_VMU/REQ_DMA)
// -----------------------------------------------------------------------------
module spm_arb_ch
  import vmu_spm_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_vmu_en,
  input  logic i_vmu_last,
  input  logic i_dma_en,
  input  logic i_dma_last,
  output logic o_vmu_gnt,
  output logic o_dma_gnt,
  output logic o_acc,
  output logic o_sel
);

  arb_state_e r_state;
  arb_state_e w_state_next;
  logic       w_vmu_gnt;
  logic       w_dma_gnt;
  logic       w_tie_pick;
  logic       w_last;

`ifdef SPM_ARB_VMU_PRIO_EN
  assign w_tie_pick = REQ_VMU;
`else
  logic r_rr;
  logic w_rr_next;
  assign w_tie_pick = r_rr;
`endif

  always_comb begin
    w_vmu_gnt    = 1'b0;
    w_dma_gnt    = 1'b0;
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_vmu_en && i_dma_en) begin
          w_vmu_gnt = (w_tie_pick == REQ_VMU);
          w_dma_gnt = (w_tie_pick == REQ_DMA);
        end else begin
          w_vmu_gnt = i_vmu_en;
          w_dma_gnt = i_dma_en;
        end
        // A multi-beat burst locks the channel to its owner.
        if (w_vmu_gnt && !i_vmu_last) begin
          w_state_next = OWN_VMU;
        end else if (w_dma_gnt && !i_dma_last) begin
          w_state_next = OWN_DMA;
        end
      end
      OWN_VMU: begin
        // A bubble (en low) keeps the lock; the other side keeps waiting.
        w_vmu_gnt = i_vmu_en;
        if (i_vmu_en && i_vmu_last) begin
          w_state_next = IDLE;
        end
      end
      OWN_DMA: begin
        w_dma_gnt = i_dma_en;
        if (i_dma_en && i_dma_last) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Grants are forced low while reset is held so a requester that keeps its
  // request up through reset sees nothing accepted.
  assign o_vmu_gnt = w_vmu_gnt & rst_n;
  assign o_dma_gnt = w_dma_gnt & rst_n;
  assign o_acc     = o_vmu_gnt | o_dma_gnt;
  assign o_sel     = o_dma_gnt ? REQ_DMA : REQ_VMU;
  assign w_last    = o_dma_gnt ? i_dma_last : i_vmu_last;

`ifndef SPM_ARB_VMU_PRIO_EN
  // The pointer flips at burst boundaries only, so the next tie after a
  // completed burst goes to the side that did not just finish.
  assign w_rr_next = (o_acc && w_last) ? other_req(o_sel) : r_rr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= REQ_VMU;
    end else begin
      r_rr <= w_rr_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

endmodule

// File: rtl/vmu_spm_arb.sv
// -----------------------------------------------------------------------------
// vmu_spm_arb
// Scratchpad port arbiter between the VMU load/store unit (requester 0) and the
// DMA engine (requester 1). Read and write channels are arbitrated
// independently by two spm_arb_ch instances; this level muxes the payload,
// registers the SPM request interface and routes read data back through a
// latency-matched tag pipeline.
//
// Configuration macro: SPM_ARB_VMU_PRIO_EN (fixed VMU priority in IDLE,
// forwarded to both channels).
//
// Parameters:
//   SCALAR_WIDTH  SPM address width
//   DATA_WIDTH    SPM data width
//   SPM_RD_LAT    cycles from o_spm_rden to i_spm_rddata valid (>= 1)
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_<r>_rden/rdaddr/rdlast        read beat request from requester r
//   o_<r>_rdgnt                     read grant (combinational)
//   i_<r>_wren/wraddr/wrdata/wrlast write beat request from requester r
//   o_<r>_wrgnt                     write grant (combinational)
//   o_spm_rden/rdaddr               registered SPM read request
//   o_spm_wren/wraddr/wrdata        registered SPM write request
//   i_spm_rddata                    SPM read data, SPM_RD_LAT after o_spm_rden
//   o_rddata                        registered read data shared by both sides
//   o_vmu_rvalid / o_dma_rvalid     o_rddata belongs to this requester
// -----------------------------------------------------------------------------
module vmu_spm_arb
  import vmu_spm_arb_pkg::*;
#(
  parameter int SCALAR_WIDTH = 32,
  parameter int DATA_WIDTH   = 256,
  parameter int SPM_RD_LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_vmu_rden,
  input  logic [SCALAR_WIDTH-1:0] i_vmu_rdaddr,
  input  logic                    i_vmu_rdlast,
  output logic                    o_vmu_rdgnt,
  input  logic                    i_dma_rden,
  input  logic [SCALAR_WIDTH-1:0] i_dma_rdaddr,
  input  logic                    i_dma_rdlast,
  output logic                    o_dma_rdgnt,
  input  logic                    i_vmu_wren,
  input  logic [SCALAR_WIDTH-1:0] i_vmu_wraddr,
  input  logic [DATA_WIDTH-1:0]   i_vmu_wrdata,
  input  logic                    i_vmu_wrlast,
  output logic                    o_vmu_wrgnt,
  input  logic                    i_dma_wren,
  input  logic [SCALAR_WIDTH-1:0] i_dma_wraddr,
  input  logic [DATA_WIDTH-1:0]   i_dma_wrdata,
  input  logic                    i_dma_wrlast,
  output logic                    o_dma_wrgnt,
  output logic                    o_spm_rden,
  output logic [SCALAR_WIDTH-1:0] o_spm_rdaddr,
  output logic                    o_spm_wren,
  output logic [SCALAR_WIDTH-1:0] o_spm_wraddr,
  output logic [DATA_WIDTH-1:0]   o_spm_wrdata,
  input  logic [DATA_WIDTH-1:0]   i_spm_rddata,
  output logic [DATA_WIDTH-1:0]   o_rddata,
  output logic                    o_vmu_rvalid,
  output logic                    o_dma_rvalid
);

  logic w_rd_acc;
  logic w_rd_sel;
  logic w_wr_acc;
  logic w_wr_sel;

  spm_arb_ch u_rd_ch (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_vmu_en   (i_vmu_rden),
    .i_vmu_last (i_vmu_rdlast),
    .i_dma_en   (i_dma_rden),
    .i_dma_last (i_dma_rdlast),
    .o_vmu_gnt  (o_vmu_rdgnt),
    .o_dma_gnt  (o_dma_rdgnt),
    .o_acc      (w_rd_acc),
    .o_sel      (w_rd_sel)
  );

  spm_arb_ch u_wr_ch (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_vmu_en   (i_vmu_wren),
    .i_vmu_last (i_vmu_wrlast),
    .i_dma_en   (i_dma_wren),
    .i_dma_last (i_dma_wrlast),
    .o_vmu_gnt  (o_vmu_wrgnt),
    .o_dma_gnt  (o_dma_wrgnt),
    .o_acc      (w_wr_acc),
    .o_sel      (w_wr_sel)
  );

  // ---------------------------------------------------------------------------
  // Registered SPM request interface. Address/data only load on an accepted
  // beat so they hold their last value through idle cycles.
  // ---------------------------------------------------------------------------
  logic                    r_spm_rden;
  logic [SCALAR_WIDTH-1:0] r_spm_rdaddr;
  logic                    r_spm_wren;
  logic [SCALAR_WIDTH-1:0] r_spm_wraddr;
  logic [DATA_WIDTH-1:0]   r_spm_wrdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spm_rden   <= 1'b0;
      r_spm_rdaddr <= '0;
    end else begin
      r_spm_rden <= w_rd_acc;
      if (w_rd_acc) begin
        r_spm_rdaddr <= (w_rd_sel == REQ_DMA) ? i_dma_rdaddr : i_vmu_rdaddr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spm_wren   <= 1'b0;
      r_spm_wraddr <= '0;
      r_spm_wrdata <= '0;
    end else begin
      r_spm_wren <= w_wr_acc;
      if (w_wr_acc) begin
        r_spm_wraddr <= (w_wr_sel == REQ_DMA) ? i_dma_wraddr : i_vmu_wraddr;
        r_spm_wrdata <= (w_wr_sel == REQ_DMA) ? i_dma_wrdata : i_vmu_wrdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return tag pipeline. Stage 0 lines up with o_spm_rden, so stage
  // SPM_RD_LAT lines up with i_spm_rddata; the output register then adds the
  // final cycle, giving SPM_RD_LAT+2 cycles from the accepted beat.
  // ---------------------------------------------------------------------------
  rd_tag_t [SPM_RD_LAT:0] r_tag;
  rd_tag_t                w_tag_in;
  rd_tag_t                w_tag_out;

  assign w_tag_in.vld = w_rd_acc;
  assign w_tag_in.src = w_rd_sel;
  assign w_tag_out    = r_tag[SPM_RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
    end else begin
      r_tag <= {r_tag[SPM_RD_LAT-1:0], w_tag_in};
    end
  end

  logic                  r_vmu_rvalid;
  logic                  r_dma_rvalid;
  logic [DATA_WIDTH-1:0] r_rddata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vmu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_rddata     <= '0;
    end else begin
      r_vmu_rvalid <= w_tag_out.vld && (w_tag_out.src == REQ_VMU);
      r_dma_rvalid <= w_tag_out.vld && (w_tag_out.src == REQ_DMA);
      if (w_tag_out.vld) begin
        r_rddata <= i_spm_rddata;
      end
    end
  end

  assign o_spm_rden   = r_spm_rden;
  assign o_spm_rdaddr = r_spm_rdaddr;
  assign o_spm_wren   = r_spm_wren;
  assign o_spm_wraddr = r_spm_wraddr;
  assign o_spm_wrdata = r_spm_wrdata;
  assign o_rddata     = r_rddata;
  assign o_vmu_rvalid = r_vmu_rvalid;
  assign o_dma_rvalid = r_dma_rvalid;

endmodule

// File: tb/tb_vmu_spm_arb.sv
// -----------------------------------------------------------------------------
// tb_vmu_spm_arb
// Directed self-checking bench for vmu_spm_arb (SPM_RD_LAT = 2). A two-stage
// SPM read model returns mk_data(addr) two cycles after o_spm_rden.
// -----------------------------------------------------------------------------
module tb_vmu_spm_arb;

  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vmu_rden, dma_rden, vmu_rdlast, dma_rdlast;
  logic [AW-1:0] vmu_rdaddr, dma_rdaddr;
  logic          vmu_rdgnt, dma_rdgnt;
  logic          vmu_wren, dma_wren, vmu_wrlast, dma_wrlast;
  logic [AW-1:0] vmu_wraddr, dma_wraddr;
  logic [DW-1:0] vmu_wrdata, dma_wrdata;
  logic          vmu_wrgnt, dma_wrgnt;
  logic          spm_rden, spm_wren;
  logic [AW-1:0] spm_rdaddr, spm_wraddr;
  logic [DW-1:0] spm_wrdata, spm_rddata, rddata;
  logic          vmu_rvalid, dma_rvalid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vmu_spm_arb #(.SCALAR_WIDTH(AW), .DATA_WIDTH(DW), .SPM_RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_vmu_rden(vmu_rden), .i_vmu_rdaddr(vmu_rdaddr), .i_vmu_rdlast(vmu_rdlast),
    .o_vmu_rdgnt(vmu_rdgnt),
    .i_dma_rden(dma_rden), .i_dma_rdaddr(dma_rdaddr), .i_dma_rdlast(dma_rdlast),
    .o_dma_rdgnt(dma_rdgnt),
    .i_vmu_wren(vmu_wren), .i_vmu_wraddr(vmu_wraddr), .i_vmu_wrdata(vmu_wrdata),
    .i_vmu_wrlast(vmu_wrlast), .o_vmu_wrgnt(vmu_wrgnt),
    .i_dma_wren(dma_wren), .i_dma_wraddr(dma_wraddr), .i_dma_wrdata(dma_wrdata),
    .i_dma_wrlast(dma_wrlast), .o_dma_wrgnt(dma_wrgnt),
    .o_spm_rden(spm_rden), .o_spm_rdaddr(spm_rdaddr),
    .o_spm_wren(spm_wren), .o_spm_wraddr(spm_wraddr), .o_spm_wrdata(spm_wrdata),
    .i_spm_rddata(spm_rddata), .o_rddata(rddata),
    .o_vmu_rvalid(vmu_rvalid), .o_dma_rvalid(dma_rvalid)
  );

  function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  // SPM model: two-cycle read latency.
  logic          m_v1, m_v2;
  logic [AW-1:0] m_a1, m_a2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v1 <= 1'b0; m_v2 <= 1'b0; m_a1 <= '0; m_a2 <= '0;
    end else begin
      m_v1 <= spm_rden; m_a1 <= spm_rdaddr;
      m_v2 <= m_v1;     m_a2 <= m_a1;
    end
  end
  assign spm_rddata = m_v2 ? mk_data(m_a2) : '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vmu_rden = 0; dma_rden = 0; vmu_rdlast = 0; dma_rdlast = 0;
    vmu_rdaddr = '0; dma_rdaddr = '0;
    vmu_wren = 0; dma_wren = 0; vmu_wrlast = 0; dma_wrlast = 0;
    vmu_wraddr = '0; dma_wraddr = '0; vmu_wrdata = '0; dma_wrdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_v;
    rst_n = 1'b0;
    idle_inputs();
    nxt(); nxt();
    #1;
    $display("step: reset state");
    chk("rst_vmu_rdgnt", vmu_rdgnt, 0);
    chk("rst_spm_rden", spm_rden, 0);
    chk("rst_spm_wren", spm_wren, 0);
    chk("rst_rvalid", {vmu_rvalid, dma_rvalid}, 0);
    chk("rst_rddata", rddata, 0);
    rst_n = 1'b1;

    // ---- VMU 4-beat read, DMA idle ----
    $display("step: vmu 4-beat read 0x10..0x13");
    nxt(); vmu_rden = 1; vmu_rdaddr = 32'h10; vmu_rdlast = 0; #1;
    chk("t1_gnt0", {vmu_rdgnt, dma_rdgnt}, 2'b10);
    nxt(); vmu_rdaddr = 32'h11; #1;
    chk("t1_gnt1", vmu_rdgnt, 1);
    chk("t1_spm0", {spm_rden, spm_rdaddr}, {1'b1, 32'h10});
    nxt(); vmu_rdaddr = 32'h12; #1;
    chk("t1_gnt2", vmu_rdgnt, 1);
    chk("t1_spm1", {spm_rden, spm_rdaddr}, {1'b1, 32'h11});
    nxt(); vmu_rdaddr = 32'h13; vmu_rdlast = 1; #1;
    chk("t1_gnt3", vmu_rdgnt, 1);
    chk("t1_spm2", {spm_rden, spm_rdaddr}, {1'b1, 32'h12});
    nxt(); vmu_rden = 0; vmu_rdlast = 0; #1;
    chk("t1_gnt_off", vmu_rdgnt, 0);
    chk("t1_spm3", {spm_rden, spm_rdaddr}, {1'b1, 32'h13});
    chk("t1_rv0", {vmu_rvalid, dma_rvalid}, 2'b10);
    chk("t1_rd0", rddata, mk_data(32'h10));
    nxt(); #1;
    chk("t1_spm_hold", {spm_rden, spm_rdaddr}, {1'b0, 32'h13});
    chk("t1_rv1", {vmu_rvalid, rddata}, {1'b1, mk_data(32'h11)});
    nxt(); #1;
    chk("t1_rv2", {vmu_rvalid, rddata}, {1'b1, mk_data(32'h12)});
    nxt(); #1;
    chk("t1_rv3", {vmu_rvalid, rddata}, {1'b1, mk_data(32'h13)});
    nxt(); #1;
    chk("t1_rv_end", {vmu_rvalid, dma_rvalid}, 2'b00);

    // ---- both request single-beat reads every cycle ----
    $display("step: contending single-beat reads");
    rst_n = 1'b0;
    nxt(); nxt(); rst_n = 1'b1;
`ifdef SPM_ARB_VMU_PRIO_EN
    exp_v = 4'b1111;
`else
    exp_v = 4'b0101;  // bit i = VMU granted in cycle i
`endif
    for (int i = 0; i < 4; i++) begin
      nxt();
      vmu_rden = 1; vmu_rdaddr = 32'h30; vmu_rdlast = 1;
      dma_rden = 1; dma_rdaddr = 32'h50; dma_rdlast = 1;
      #1;
      chk($sformatf("t2_vmu_gnt%0d", i), vmu_rdgnt, exp_v[i]);
      chk($sformatf("t2_dma_gnt%0d", i), dma_rdgnt, !exp_v[i]);
      if (i == 1) chk("t2_spm_addr", spm_rdaddr, 32'h30);
    end
    nxt(); idle_inputs();
    repeat (5) nxt();

    // ---- interleaved single reads vmu, dma, vmu ----
    $display("step: interleaved reads vmu 0x60, dma 0x70, vmu 0x61");
    nxt(); vmu_rden = 1; vmu_rdaddr = 32'h60; vmu_rdlast = 1; #1;
    chk("t6_g0", {vmu_rdgnt, dma_rdgnt}, 2'b10);
    nxt(); vmu_rden = 0; dma_rden = 1; dma_rdaddr = 32'h70; dma_rdlast = 1; #1;
    chk("t6_g1", {vmu_rdgnt, dma_rdgnt}, 2'b01);
    nxt(); dma_rden = 0; vmu_rden = 1; vmu_rdaddr = 32'h61; #1;
    chk("t6_g2", {vmu_rdgnt, dma_rdgnt}, 2'b10);
    nxt(); vmu_rden = 0; #1;
    chk("t6_rv_early", {vmu_rvalid, dma_rvalid}, 2'b00);
    nxt(); #1;
    chk("t6_rv0", {vmu_rvalid, dma_rvalid, rddata}, {2'b10, mk_data(32'h60)});
    nxt(); #1;
    chk("t6_rv1", {vmu_rvalid, dma_rvalid, rddata}, {2'b01, mk_data(32'h70)});
    nxt(); #1;
    chk("t6_rv2", {vmu_rvalid, dma_rvalid, rddata}, {2'b10, mk_data(32'h61)});
    nxt(); #1;
    chk("t6_rv_end", {vmu_rvalid, dma_rvalid}, 2'b00);
    idle_inputs();

    // ---- DMA owns 3-beat write with a bubble, VMU waits ----
    $display("step: dma 3-beat write with bubble, vmu waiting");
    nxt(); dma_wren = 1; dma_wraddr = 32'h80; dma_wrdata = 256'hD0; dma_wrlast = 0; #1;
    chk("t3_g0", {vmu_wrgnt, dma_wrgnt}, 2'b01);
    nxt(); dma_wren = 0;
    vmu_wren = 1; vmu_wraddr = 32'h90; vmu_wrdata = 256'h99; vmu_wrlast = 1; #1;
    chk("t3_bubble_gnt", {vmu_wrgnt, dma_wrgnt}, 2'b00);
    chk("t3_spm0", {spm_wren, spm_wraddr, spm_wrdata}, {1'b1, 32'h80, 256'hD0});
    nxt(); dma_wren = 1; dma_wraddr = 32'h81; dma_wrdata = 256'hD1; #1;
    chk("t3_g1", {vmu_wrgnt, dma_wrgnt}, 2'b01);
    chk("t3_spm_bub", {spm_wren, spm_wraddr}, {1'b0, 32'h80});
    nxt(); dma_wraddr = 32'h82; dma_wrdata = 256'hD2; dma_wrlast = 1; #1;
    chk("t3_g2", {vmu_wrgnt, dma_wrgnt}, 2'b01);
    chk("t3_spm1", {spm_wren, spm_wraddr, spm_wrdata}, {1'b1, 32'h81, 256'hD1});
    nxt(); dma_wren = 0; dma_wrlast = 0; #1;
    chk("t3_vmu_after", {vmu_wrgnt, dma_wrgnt}, 2'b10);
    chk("t3_spm2", {spm_wren, spm_wraddr, spm_wrdata}, {1'b1, 32'h82, 256'hD2});
    nxt(); vmu_wren = 0; vmu_wrlast = 0; #1;
    chk("t3_spm_vmu", {spm_wren, spm_wraddr, spm_wrdata}, {1'b1, 32'h90, 256'h99});
    nxt(); #1;
    chk("t3_spm_idle", spm_wren, 0);
    idle_inputs();

    // ---- VMU read and DMA write in the same cycle ----
    $display("step: vmu read 0x20 + dma write 0x40/0xAA");
    nxt();
    vmu_rden = 1; vmu_rdaddr = 32'h20; vmu_rdlast = 1;
    dma_wren = 1; dma_wraddr = 32'h40; dma_wrdata = 256'hAA; dma_wrlast = 1; #1;
    chk("t4_gnts", {vmu_rdgnt, dma_rdgnt, vmu_wrgnt, dma_wrgnt}, 4'b1001);
    nxt(); idle_inputs(); #1;
    chk("t4_spm_rd", {spm_rden, spm_rdaddr}, {1'b1, 32'h20});
    chk("t4_spm_wr", {spm_wren, spm_wraddr, spm_wrdata}, {1'b1, 32'h40, 256'hAA});
    nxt(); nxt(); #1;
    chk("t4_rv_early", {vmu_rvalid, dma_rvalid}, 2'b00);
    nxt(); #1;
    chk("t4_rv", {vmu_rvalid, dma_rvalid, rddata}, {2'b10, mk_data(32'h20)});
    nxt(); #1;
    chk("t4_rv_end", {vmu_rvalid, dma_rvalid}, 2'b00);

    // ---- reset in the middle of a DMA 4-beat read ----
    $display("step: reset mid dma read burst");
    nxt(); dma_rden = 1; dma_rdaddr = 32'hA0; dma_rdlast = 0; #1;
    chk("t5_g0", dma_rdgnt, 1);
    nxt(); dma_rdaddr = 32'hA1; #1;
    chk("t5_g1", dma_rdgnt, 1);
    nxt(); dma_rdaddr = 32'hA2; rst_n = 1'b0; #1;
    chk("t5_rst_gnt", {vmu_rdgnt, dma_rdgnt, vmu_wrgnt, dma_wrgnt}, 4'b0000);
    chk("t5_rst_spm", {spm_rden, spm_rdaddr, spm_wren}, '0);
    chk("t5_rst_rv", {vmu_rvalid, dma_rvalid, rddata}, '0);
    nxt(); #1;
    chk("t5_rst_rv2", dma_rvalid, 0);
    nxt(); rst_n = 1'b1;
    vmu_rden = 1; vmu_rdaddr = 32'hB0; vmu_rdlast = 1;
    dma_rdaddr = 32'hA0; dma_rdlast = 1; #1;
    chk("t5_first_gnt", {vmu_rdgnt, dma_rdgnt}, 2'b10);
    chk("t5_no_rv0", dma_rvalid, 0);
    nxt(); vmu_rden = 0; #1;
    chk("t5_dma_gnt", {vmu_rdgnt, dma_rdgnt}, 2'b01);
    chk("t5_no_rv1", dma_rvalid, 0);
    nxt(); dma_rden = 0; #1;
    chk("t5_no_rv2", dma_rvalid, 0);
    nxt(); #1;
    chk("t5_no_rv3", {vmu_rvalid, dma_rvalid}, 2'b00);
    nxt(); #1;
    chk("t5_rv_vmu", {vmu_rvalid, dma_rvalid, rddata}, {2'b10, mk_data(32'hB0)});
    nxt(); #1;
    chk("t5_rv_dma", {vmu_rvalid, dma_rvalid, rddata}, {2'b01, mk_data(32'hA0)});
    idle_inputs();
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
